hc_ctrl: RTL and testbench

Sequencer for the HC stream cipher datapath. It issues one table operation at a time to the datapath over a valid/ready/done handshake, in this order: key/IV load, W-expansion into P/Q, 1024 discarded mixing steps, then one keystream step per `next` request. It sits between the user-facing `init`/`next` strobes and the P/Q table datapath, and owns the step counter and the keyed state.

---
 rtl/hc_pkg.sv | 38 +++
 rtl/hc_ctrl_if.sv | 28 ++
 rtl/hc_op_hs.sv | 66 ++++++
 rtl/hc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hc_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hc_pkg.sv
// hc_pkg: definitions shared by the HC stream cipher controller and datapath.
// Holds the operation codes, table geometry, the controller state encoding
// and the phase encoding of the single-outstanding operation handshake.
package hc_pkg;

  localparam logic [1:0] HC_OP_LOAD   = 2'd0;
  localparam logic [1:0] HC_OP_EXPAND = 2'd1;
  localparam logic [1:0] HC_OP_MIX    = 2'd2;
  localparam logic [1:0] HC_OP_GEN    = 2'd3;

  localparam int HC_LOAD_WORDS  = 16;
  localparam int HC_W_WORDS     = 1280;
  localparam int HC_TABLE_WORDS = 512;

  localparam int HC_IDX_W  = 11;
  localparam int HC_STEP_W = 10;

  typedef enum logic [2:0] {
    HC_ST_IDLE,
    HC_ST_LOAD,
    HC_ST_EXPAND,
    HC_ST_MIX,
    HC_ST_KEYED,
    HC_ST_GEN
  } hc_state_t;

  typedef enum logic [1:0] {
    HC_HS_IDLE,
    HC_HS_ISSUE,
    HC_HS_WAIT
  } hc_hs_phase_t;

  // MIX/GEN operation index: step counter i, bit 9 selects the Q table.
  function automatic logic [HC_IDX_W-1:0] hc_step_idx(input logic [HC_STEP_W-1:0] i);
    return {1'b0, i};
  endfunction

endpackage

// File: rtl/hc_ctrl_if.sv
// hc_ctrl_if: operation channel between the HC sequencer and the P/Q table
// datapath. valid/ready transfers an operation, done reports its completion.
interface hc_ctrl_if;
  import hc_pkg::*;

  logic                op_valid;
  logic                op_ready;
  logic [1:0]          op_code;
  logic [HC_IDX_W-1:0] op_idx;
  logic                op_done;

  modport master (
    output op_valid,
    output op_code,
    output op_idx,
    input  op_ready,
    input  op_done
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  op_idx,
    output op_ready,
    output op_done
  );

endinterface

// File: rtl/hc_op_hs.sv
// hc_op_hs: single-outstanding valid/ready/done tracker.
// ISSUE holds op_valid until op_ready; WAIT holds until op_done. A new
// operation may be issued in the same cycle the previous one completes.
// abort withdraws an offered but not yet accepted operation; an accepted
// operation always runs to op_done.
module hc_op_hs
  import hc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic issue,
  input  logic abort,
  input  logic op_ready,
  input  logic op_done,
  output logic op_valid,
  output logic hs_idle,
  output logic hs_done
);

  hc_hs_phase_t phase;

  assign hs_idle = (phase == HC_HS_IDLE);
  // op_done only counts once the operation has been accepted.
  assign hs_done = (phase == HC_HS_WAIT) && op_done;

  // Handshake phase and the registered op_valid it drives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= HC_HS_IDLE;
      op_valid <= 1'b0;
    end else begin
      case (phase)
        HC_HS_IDLE: begin
          if (issue) begin
            phase    <= HC_HS_ISSUE;
            op_valid <= 1'b1;
          end
        end
        HC_HS_ISSUE: begin
          if (op_ready) begin
            phase    <= HC_HS_WAIT;
            op_valid <= 1'b0;
          end else if (abort) begin
            phase    <= HC_HS_IDLE;
            op_valid <= 1'b0;
          end
        end
        HC_HS_WAIT: begin
          if (op_done) begin
            if (issue) begin
              phase    <= HC_HS_ISSUE;
              op_valid <= 1'b1;
            end else begin
              phase <= HC_HS_IDLE;
            end
          end
        end
        default: begin
          phase    <= HC_HS_IDLE;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hc_ctrl.sv
// hc_ctrl: sequencer for the HC stream cipher datapath.
// Keying runs LOAD (idx 0..15), EXPAND (idx 16..1279) and MIX_STEPS
// discarded MIX steps; each next request in KEYED then issues one GEN step.
// The 10-bit step counter i is cleared at MIX entry and keeps running into
// GEN. An init during a sequence is held pending until the outstanding
// operation has finished its handshake, then keying restarts at LOAD idx 0.
// Optional feature macro: HC_CTRL_KS_COUNT_EN adds the 64-bit keystream word
// counter ks_count; without it ks_count is constant zero.
module hc_ctrl
  import hc_pkg::*;
#(
  parameter int MIX_STEPS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        next,
  hc_ctrl_if.master   op,
  output logic        busy,
  output logic        keyed,
  output logic        word_done,
  output logic [63:0] ks_count
);

  localparam logic [HC_STEP_W-1:0] MIX_LAST  = HC_STEP_W'(MIX_STEPS - 1);
  localparam logic [HC_IDX_W-1:0]  LOAD_LAST = HC_IDX_W'(HC_LOAD_WORDS - 1);
  localparam logic [HC_IDX_W-1:0]  W_LAST    = HC_IDX_W'(HC_W_WORDS - 1);

  hc_state_t            state;
  logic                 pend_init;
  logic [HC_STEP_W-1:0] step_i;

  logic hs_idle;
  logic hs_done;
  logic in_seq;
  logic init_any;
  logic mix_last;
  logic start_load;
  logic accept_next;
  logic advance;
  logic continue_issue;
  logic issue;

  assign in_seq   = (state == HC_ST_LOAD) || (state == HC_ST_EXPAND) ||
                    (state == HC_ST_MIX)  || (state == HC_ST_GEN);
  assign init_any = init || pend_init;
  assign mix_last = (state == HC_ST_MIX) && (step_i == MIX_LAST);

  // (Re)keying starts once no operation is outstanding or the current one completes.
  assign start_load     = init_any && (hs_idle || hs_done);
  // init takes priority over a coincident next.
  assign accept_next    = next && !init && (state == HC_ST_KEYED);
  assign advance        = hs_done && !init_any;
  assign continue_issue = advance && ((state == HC_ST_LOAD) || (state == HC_ST_EXPAND) ||
                                      ((state == HC_ST_MIX) && !mix_last));
  assign issue          = start_load || accept_next || continue_issue;

  hc_op_hs u_hs (
    .clk      (clk),
    .reset_n  (reset_n),
    .issue    (issue),
    .abort    (init_any),
    .op_ready (op.op_ready),
    .op_done  (op.op_done),
    .op_valid (op.op_valid),
    .hs_idle  (hs_idle),
    .hs_done  (hs_done)
  );

  // Sequencer state, operation code/index and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HC_ST_IDLE;
      pend_init  <= 1'b0;
      step_i     <= '0;
      op.op_code <= HC_OP_LOAD;
      op.op_idx  <= '0;
      busy       <= 1'b0;
      keyed      <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      word_done <= 1'b0;

      if (start_load) begin
        pend_init <= 1'b0;
      end else if (init && in_seq) begin
        pend_init <= 1'b1;
      end

      if (init && in_seq) begin
        keyed <= 1'b0;
      end

      if (start_load) begin
        state      <= HC_ST_LOAD;
        op.op_code <= HC_OP_LOAD;
        op.op_idx  <= '0;
        busy       <= 1'b1;
        keyed      <= 1'b0;
      end else if (accept_next) begin
        state      <= HC_ST_GEN;
        op.op_code <= HC_OP_GEN;
        op.op_idx  <= hc_step_idx(step_i);
        busy       <= 1'b1;
      end else if (advance) begin
        case (state)
          HC_ST_LOAD: begin
            op.op_idx <= op.op_idx + 11'd1;
            if (op.op_idx == LOAD_LAST) begin
              state      <= HC_ST_EXPAND;
              op.op_code <= HC_OP_EXPAND;
            end
          end
          HC_ST_EXPAND: begin
            if (op.op_idx == W_LAST) begin
              state      <= HC_ST_MIX;
              op.op_code <= HC_OP_MIX;
              op.op_idx  <= '0;
              step_i     <= '0;
            end else begin
              op.op_idx <= op.op_idx + 11'd1;
            end
          end
          HC_ST_MIX: begin
            step_i <= step_i + 10'd1;
            if (mix_last) begin
              state <= HC_ST_KEYED;
              busy  <= 1'b0;
              keyed <= 1'b1;
            end else begin
              op.op_idx <= hc_step_idx(step_i + 10'd1);
            end
          end
          HC_ST_GEN: begin
            step_i    <= step_i + 10'd1;
            state     <= HC_ST_KEYED;
            busy      <= 1'b0;
            word_done <= 1'b1;
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

`ifdef HC_CTRL_KS_COUNT_EN
  // Keystream words produced since the last rekey; steps with each word_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ks_count <= '0;
    end else if (start_load) begin
      ks_count <= '0;
    end else if (advance && (state == HC_ST_GEN)) begin
      ks_count <= ks_count + 64'd1;
    end
  end
`else
  assign ks_count = '0;
`endif

endmodule

// File: tb/tb_hc_ctrl.sv
// tb_hc_ctrl: scoreboard bench for hc_ctrl at MIX_STEPS=1024.
// Stimulus pushes expected {op_code, op_idx} into a queue; a monitor pops and
// compares on every transfer. A datapath model answers op_done one cycle
// after each transfer (longer for one selected EXPAND index).
module tb_hc_ctrl;
  import hc_pkg::*;

  typedef struct packed {
    logic [1:0]  code;
    logic [10:0] idx;
  } op_t;

`ifdef HC_CTRL_KS_COUNT_EN
  localparam bit KS_EN = 1'b1;
`else
  localparam bit KS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        init = 1'b0;
  logic        next = 1'b0;
  logic        busy;
  logic        keyed;
  logic        word_done;
  logic [63:0] ks_count;

  hc_ctrl_if op_if ();

  hc_ctrl #(.MIX_STEPS(1024)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (init),
    .next      (next),
    .op        (op_if),
    .busy      (busy),
    .keyed     (keyed),
    .word_done (word_done),
    .ks_count  (ks_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks = 0;
  int  errors = 0;
  op_t exp_q[$];
  int  wd_seen = 0;
  int  stall_idx = -1;
  int  stall_len = 0;

  op_t mon_got;
  op_t mon_exp;

  int          dp_cnt = 0;
  bit          dp_xf;
  logic [10:0] dp_idx;
  logic [1:0]  dp_code;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every transfer against the scoreboard, count word_done.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && op_if.op_valid && op_if.op_ready) begin
        mon_got.code = op_if.op_code;
        mon_got.idx  = op_if.op_idx;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL op_unexpected: got code %0d idx %0d, none expected (cycle %0d)",
                   mon_got.code, mon_got.idx, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          check("op_transfer", 64'(mon_got), 64'(mon_exp));
        end
      end
      if (reset_n && word_done) wd_seen++;
    end
  end

  // Datapath model: op_done one cycle after transfer, delayed for stall_idx.
  initial begin
    op_if.op_done = 1'b0;
    forever begin
      @(negedge clk);
      dp_xf   = reset_n && op_if.op_valid && op_if.op_ready;
      dp_idx  = op_if.op_idx;
      dp_code = op_if.op_code;
      @(posedge clk);
      #1;
      if (!reset_n) dp_cnt = 0;
      else if (dp_xf)
        dp_cnt = (dp_code == HC_OP_EXPAND && int'(dp_idx) == stall_idx) ? stall_len + 1 : 1;
      op_if.op_done = reset_n && (dp_cnt == 1);
      if (dp_cnt > 0) dp_cnt--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic push_op(input logic [1:0] c, input int i);
    op_t t;
    t.code = c;
    t.idx  = 11'(i);
    exp_q.push_back(t);
  endtask

  task automatic push_keying();
    for (int i = 0; i < 16; i++) push_op(HC_OP_LOAD, i);
    for (int i = 16; i < 1280; i++) push_op(HC_OP_EXPAND, i);
    for (int i = 0; i < 1024; i++) push_op(HC_OP_MIX, i);
  endtask

  task automatic wait_keyed(output int c);
    int n = 0;
    while (!keyed && n < 8000) begin
      tick();
      n++;
    end
    c = cyc;
    check("keyed_rise", 64'(keyed), 64'd1);
  endtask

  task automatic wait_op(input logic [1:0] code, input int idx);
    int n = 0;
    while (!(op_if.op_valid && op_if.op_code == code && int'(op_if.op_idx) == idx) && n < 8000) begin
      tick();
      n++;
    end
    check("wait_op_found",
          64'(op_if.op_valid && op_if.op_code == code && int'(op_if.op_idx) == idx), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_valid"},  64'(op_if.op_valid), 64'd0);
    check({tag, "_op_code"},   64'(op_if.op_code),  64'd0);
    check({tag, "_op_idx"},    64'(op_if.op_idx),   64'd0);
    check({tag, "_busy"},      64'(busy),           64'd0);
    check({tag, "_keyed"},     64'(keyed),          64'd0);
    check({tag, "_word_done"}, 64'(word_done),      64'd0);
    check({tag, "_ks_count"},  ks_count,            64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int c;
    int c0;
    int s;
    int w;
    bit stable;
    logic [1:0]  cap_code;
    logic [10:0] cap_idx;

    op_if.op_ready = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    // Full keying sequence and its latency.
    push_keying();
    t = cyc;
    pulse_init();
    check("busy_t1", 64'(busy), 64'd1);
    check("valid_t1", 64'(op_if.op_valid), 64'd1);
    check("code_t1", 64'(op_if.op_code), 64'(HC_OP_LOAD));
    wait_keyed(c);
    check("keyed_time", 64'(c), 64'(t + 4609));
    check("busy_at_keyed", 64'(busy), 64'd0);
    check("queue_empty_keying", 64'(exp_q.size()), 64'd0);

    // Three next pulses spaced 4 cycles.
    for (int k = 0; k < 3; k++) begin
      push_op(HC_OP_GEN, k);
      pulse_next();
      check("gen_valid", 64'(op_if.op_valid), 64'd1);
      check("gen_code", 64'(op_if.op_code), 64'(HC_OP_GEN));
      tick();
      tick();
      check("gen_word_done", 64'(word_done), 64'd1);
      check("gen_keyed", 64'(keyed), 64'd1);
      tick();
    end
    check("word_done_count3", 64'(wd_seen), 64'd3);
    check("ks_count3", ks_count, KS_EN ? 64'd3 : 64'd0);

    // 1030 back-to-back GEN steps, next re-issued 3 cycles after each.
    for (int k = 0; k < 1030; k++) begin
      push_op(HC_OP_GEN, (3 + k) % 1024);
      pulse_next();
      tick();
      tick();
    end
    tick();
    check("word_done_count_wrap", 64'(wd_seen), 64'd1033);
    check("ks_count_wrap", ks_count, KS_EN ? 64'd1033 : 64'd0);
    check("queue_empty_gen", 64'(exp_q.size()), 64'd0);

    // Rekey, then init while EXPAND idx 700 waits for its op_done.
    for (int i = 0; i < 16; i++) push_op(HC_OP_LOAD, i);
    for (int i = 16; i <= 700; i++) push_op(HC_OP_EXPAND, i);
    stall_idx = 700;
    stall_len = 10;
    pulse_init();
    check("rekey_ks_cleared", ks_count, 64'd0);
    check("rekey_keyed_cleared", 64'(keyed), 64'd0);
    wait_op(HC_OP_EXPAND, 700);
    c0 = cyc;
    tick();
    pulse_init();
    check("abort_keyed_low", 64'(keyed), 64'd0);
    push_keying();
    s = 0;
    while (!op_if.op_valid && s < 100) begin
      tick();
      s++;
    end
    check("abort_restart_cycle", 64'(cyc), 64'(c0 + 12));
    check("abort_restart_code", 64'(op_if.op_code), 64'(HC_OP_LOAD));
    check("abort_restart_idx", 64'(op_if.op_idx), 64'd0);
    check("abort_ks_count", ks_count, 64'd0);
    stall_idx = -1;
    s = cyc;
    wait_keyed(c);
    check("keyed_time_abort", 64'(c), 64'(s + 4608));
    check("queue_empty_abort", 64'(exp_q.size()), 64'd0);

    // init and next together while keyed; next during MIX.
    push_keying();
    t = cyc;
    init = 1'b1;
    next = 1'b1;
    tick();
    init = 1'b0;
    next = 1'b0;
    check("init_next_valid", 64'(op_if.op_valid), 64'd1);
    check("init_next_code", 64'(op_if.op_code), 64'(HC_OP_LOAD));
    wait_op(HC_OP_MIX, 5);
    w = wd_seen;
    pulse_next();
    wait_keyed(c);
    check("keyed_time_init_next", 64'(c), 64'(t + 4609));
    check("mix_next_no_word", 64'(wd_seen), 64'(w));
    check("queue_empty_init_next", 64'(exp_q.size()), 64'd0);

    // op_ready held low for 50 cycles, then reset mid-MIX.
    push_keying();
    pulse_init();
    wait_op(HC_OP_EXPAND, 299);
    op_if.op_ready = 1'b0;
    cap_code = op_if.op_code;
    cap_idx  = op_if.op_idx;
    stable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!(op_if.op_valid && op_if.op_code == cap_code && op_if.op_idx == cap_idx)) stable = 1'b0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    check("stall_idx", 64'(op_if.op_idx), 64'd299);
    op_if.op_ready = 1'b1;
    wait_op(HC_OP_MIX, 40);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_mix_rst");
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    pulse_next();
    tick();
    check("idle_next_ignored", 64'(op_if.op_valid), 64'd0);
    check("idle_next_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
